fetch_queue: RTL and testbench

//   Instruction fetch queue between the fetch stage and decode/rename. Buffers
//   {pc, inst} pairs from fetch so an imem response is never lost when the

---
 rtl/core_pkg.sv | 12 +
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: instruction width, fetch-queue entry layout and default depth.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode; flushed on branch redirect.
// Optional same-cycle empty-queue bypass enabled with FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = core_pkg::XLEN
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enq_valid_i,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [XLEN-1:0]          enq_inst_i,
    output logic                     enq_ready_o,
    output logic                     deq_valid_o,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [XLEN-1:0]          deq_inst_o,
    input  logic                     deq_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [PW-1:0]   head_q, tail_q, count_q;
    logic [PW-1:0]   head_n, tail_n;
    logic            full_q;
    logic [DEPTH-1:0] vld_q;
    fq_entry_t       mem_q [DEPTH];

    logic [AW-1:0]   head_idx, tail_idx;
    logic            empty, head_vld;
    logic            enq_fire, deq_fire, bypass, store, pop;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign empty    = (head_q == tail_q);
    assign head_vld = vld_q[head_idx];

    // Ready comes only from the registered full flag, so a pop never frees a slot the same cycle.
    assign enq_ready_o = !full_q;
    assign enq_fire    = enq_valid_i && !full_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && enq_fire && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid_o = head_vld || bypass;
    assign deq_fire    = deq_valid_o && deq_ready_i;
    // A bypassed entry consumed this cycle never touches storage.
    assign store       = enq_fire && !(bypass && deq_ready_i);
    assign pop         = deq_fire && !bypass;

    assign head_n  = pop   ? head_q + ONE_C : head_q;
    assign tail_n  = store ? tail_q + ONE_C : tail_q;
    assign count_o = count_q;

    always_comb begin
        deq_pc_o   = '0;
        deq_inst_o = '0;
        if (bypass) begin
            deq_pc_o   = enq_pc_i;
            deq_inst_o = enq_inst_i;
        end else if (head_vld) begin
            deq_pc_o   = mem_q[head_idx].pc;
            deq_inst_o = mem_q[head_idx].inst;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            vld_q   <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= tail_n - head_n;
            full_q  <= (tail_n[AW-1:0] == head_n[AW-1:0]) && (tail_n[AW] != head_n[AW]);
            if (store) vld_q[tail_idx] <= 1'b1;
            if (pop)   vld_q[head_idx] <= 1'b0;
        end
    end

    // Payload storage carries no reset; validity lives in vld_q.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[tail_idx].pc   <= enq_pc_i;
            mem_q[tail_idx].inst <= enq_inst_i;
        end
    end

    a_count_range: assert property (@(posedge clk_i) disable iff (!reset_i)
        count_q <= DEPTH_C);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(pop && (count_q == '0)));
    a_vld_consistent: assert property (@(posedge clk_i) disable iff (!reset_i)
        head_vld == (count_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   reset_i;
    logic                   enq_valid_i;
    logic [XLEN-1:0]        enq_pc_i;
    logic [XLEN-1:0]        enq_inst_i;
    logic                   enq_ready_o;
    logic                   deq_valid_o;
    logic [XLEN-1:0]        deq_pc_o;
    logic [XLEN-1:0]        deq_inst_o;
    logic                   deq_ready_i;
    logic                   flush_i;
    logic [$clog2(DEPTH):0] count_o;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .deq_ready_i (deq_ready_i),
        .flush_i     (flush_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of {pc, inst} pairs in arrival order.
    logic [2*XLEN-1:0] model_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Called just after a falling edge: drive, compare, advance model, wait one cycle.
    task automatic cycle(input logic ev, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                         input logic dr, input logic fl);
        int  sz;
        bit  byp, exp_valid, enq_ok;
        logic [2*XLEN-1:0] head;
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_inst_i  = inst;
        deq_ready_i = dr;
        flush_i     = fl;
        #1;
        sz        = model_q.size();
        enq_ok    = ev && (sz < DEPTH);
        byp       = BYP && (sz == 0) && enq_ok && !fl;
        exp_valid = (sz > 0) || byp;
        head      = byp ? {pc, inst} : ((sz > 0) ? model_q[0] : '0);
        check("count", 64'(count_o), 64'(sz));
        check("enq_ready", 64'(enq_ready_o), 64'(sz < DEPTH));
        check("deq_valid", 64'(deq_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            check("deq_pc", 64'(deq_pc_o), 64'(head[2*XLEN-1:XLEN]));
            check("deq_inst", 64'(deq_inst_o), 64'(head[XLEN-1:0]));
        end
        if (fl) begin
            model_q.delete();
        end else begin
            if (exp_valid && dr && !byp) void'(model_q.pop_front());
            if (enq_ok && !(byp && dr)) model_q.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i    = '0;
        enq_inst_i  = '0;
        deq_ready_i = 1'b0;
        flush_i     = 1'b0;
        #12;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(deq_valid_o), 64'd0);
        check("rst_ready", 64'(enq_ready_o), 64'd1);
        check("rst_pc", 64'(deq_pc_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);

        // Mid-stream asynchronous reset after three enqueues
        for (int i = 0; i < 3; i++) cycle(1'b1, XLEN'(32'h100 + 4*i), XLEN'(32'hA000 + i), 1'b0, 1'b0);
        enq_valid_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_valid", 64'(deq_valid_o), 64'd0);
        check("mid_rst_ready", 64'(enq_ready_o), 64'd1);
        check("mid_rst_pc", 64'(deq_pc_o), 64'd0);
        model_q.delete();
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);

        // Fill to full, fifth refused, drain in order
        for (int i = 0; i < 4; i++) cycle(1'b1, XLEN'(4*i), ~XLEN'(4*i), 1'b0, 1'b0);
        cycle(1'b1, 32'h10, ~32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Wrap with occupancy held at two
        cycle(1'b1, 32'h200, 32'h1200, 1'b0, 1'b0);
        cycle(1'b1, 32'h204, 32'h1204, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, XLEN'(32'h208 + 4*i), XLEN'(32'h1208 + 4*i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with three entries and a concurrent enqueue
        for (int i = 0; i < 3; i++) cycle(1'b1, XLEN'(32'h300 + 4*i), XLEN'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 32'h40, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Full with simultaneous dequeue: pop happens, enqueue refused, then accepted
        for (int i = 0; i < 4; i++) cycle(1'b1, XLEN'(32'h400 + 4*i), XLEN'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h500, 32'h5, 1'b1, 1'b0);
        cycle(1'b1, 32'h500, 32'h5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Empty queue, enqueue with decode ready: same-cycle or next-cycle visibility
        cycle(1'b1, 32'h20, 32'h2020, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        // Randomized traffic with varying bias
        for (int i = 0; i < 2000; i++) begin
            int pe, pd;
            pe = (i < 1000) ? 70 : 35;
            pd = (i < 1000) ? 35 : 70;
            cycle(($urandom_range(0, 99) < pe), XLEN'($urandom) & ~XLEN'(3), XLEN'($urandom),
                  ($urandom_range(0, 99) < pd), ($urandom_range(0, 99) < 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
